// File: rtl/spi_master_fsm_pkg.sv
// Shared types and defaults for the SPI master: state encoding, default
// geometry, and state-class helpers used by the FSM and the bit timer.
package spi_pkg;

  localparam int DEF_RW_FLAG      = 1;
  localparam int DEF_ADDR_WIDTH   = 3;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_CMD_WIDTH    = DEF_RW_FLAG + DEF_ADDR_WIDTH + DEF_DATA_WIDTH;
  localparam int DEF_CLK_DIV      = 10;
  localparam int DEF_DELAY_CYCLES = 180;

  typedef enum logic [3:0] {
    IDLE           = 4'd0,
    W_SEND         = 4'd1,
    R_SEND_CMD     = 4'd2,
    R_DELAY        = 4'd3,
    R_REV_DATA     = 4'd4,
    SEND_READ_DATA = 4'd5
  } state_t;

  // States in which sclk toggles.
  function automatic logic is_shift(state_t s);
    return (s == W_SEND) || (s == R_SEND_CMD) || (s == R_REV_DATA);
  endfunction

  // States that drive mosi from the transmit shift register.
  function automatic logic is_tx(state_t s);
    return (s == W_SEND) || (s == R_SEND_CMD);
  endfunction

  // States that hold chip select asserted (low).
  function automatic logic cs_active(state_t s);
    return (s == W_SEND) || (s == R_SEND_CMD) || (s == R_DELAY) || (s == R_REV_DATA);
  endfunction

endpackage

// File: rtl/spi_master_fsm_if.sv
// Command/response port between a register-access client and the SPI master.
// The client side uses modport master, the controller uses modport slave.
interface spi_master_fsm_if
  import spi_pkg::*;
#(
  parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CMD_WIDTH-1:0]  cmd_data;
  logic                  read_valid;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output cmd_valid,
    output cmd_data,
    input  cmd_ready,
    input  read_valid,
    input  read_data
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    output cmd_ready,
    output read_valid,
    output read_data
  );

endinterface

// File: rtl/spi_master_fsm_bit_timer.sv
// Per-bit clock divider for the SPI master. bit_start looks one cycle ahead
// (the coming cycle is count 0) so registered mosi lands exactly on count 0.
module spi_bit_timer
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic en_nxt,
  output logic bit_start,
  output logic sample,
  output logic bit_end,
  output logic sclk
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = '0;
    if (en && (cnt != LAST)) cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      sclk <= en_nxt && (cnt_nxt >= HALF);
    end
  end

  assign bit_start = en_nxt && (cnt_nxt == '0);
  assign sample    = en && (cnt == HALF);
  assign bit_end   = en && (cnt == LAST);

endmodule

// File: rtl/spi_master_fsm.sv
// Single-channel SPI master (mode 0, MSB first): turns one {rw, addr, data}
// command into a write transaction or a read with turnaround delay.
module spi_master_fsm
  import spi_pkg::*;
#(
  parameter int RW_FLAG      = DEF_RW_FLAG,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CMD_WIDTH    = RW_FLAG + ADDR_WIDTH + DATA_WIDTH,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int DELAY_CYCLES = DEF_DELAY_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_master_fsm_if.slave  cmd_if,
  output logic             sclk,
  output logic             cs,
  output logic             mosi,
  input  logic             miso
);

  localparam int HDR_BITS = RW_FLAG + ADDR_WIDTH;
  localparam int BCW      = $clog2(CMD_WIDTH + 1);
  localparam int DCW      = $clog2(DELAY_CYCLES + 1);

  localparam logic [BCW-1:0] LAST_W_BIT = BCW'(CMD_WIDTH - 1);
  localparam logic [BCW-1:0] LAST_H_BIT = BCW'(HDR_BITS - 1);
  localparam logic [BCW-1:0] LAST_R_BIT = BCW'(DATA_WIDTH - 1);
  localparam logic [DCW-1:0] LAST_DLY   = DCW'(DELAY_CYCLES - 1);

  state_t                state;
  state_t                state_nxt;
  logic [CMD_WIDTH-1:0]  tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic [BCW-1:0]        bit_cnt;
  logic [DCW-1:0]        dly_cnt;
  logic                  read_valid_q;
  logic                  cs_q;
  logic                  mosi_q;
  logic                  accept;
  logic                  bit_start;
  logic                  sample;
  logic                  bit_end;

  assign accept = cmd_if.cmd_valid && (state == IDLE);

  spi_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (is_shift(state)),
    .en_nxt    (is_shift(state_nxt)),
    .bit_start (bit_start),
    .sample    (sample),
    .bit_end   (bit_end),
    .sclk      (sclk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_if.cmd_valid)
          state_nxt = cmd_if.cmd_data[CMD_WIDTH-1] ? W_SEND : R_SEND_CMD;
      end
      W_SEND: begin
        if (bit_end && (bit_cnt == LAST_W_BIT)) state_nxt = IDLE;
      end
      R_SEND_CMD: begin
        if (bit_end && (bit_cnt == LAST_H_BIT)) state_nxt = R_DELAY;
      end
      R_DELAY: begin
        if (dly_cnt == LAST_DLY) state_nxt = R_REV_DATA;
      end
      R_REV_DATA: begin
        if (bit_end && (bit_cnt == LAST_R_BIT)) state_nxt = SEND_READ_DATA;
      end
      SEND_READ_DATA: state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  // Shift registers and bit/delay counters; bit_cnt restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      dly_cnt <= '0;
    end else begin
      if (accept)
        tx_sr <= cmd_if.cmd_data;
      else if (bit_end && is_tx(state))
        tx_sr <= tx_sr << 1;

      if (sample && (state == R_REV_DATA))
        rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};

      if (state_nxt != state) bit_cnt <= '0;
      else if (bit_end)       bit_cnt <= bit_cnt + 1'b1;

      if (state == R_DELAY) dly_cnt <= dly_cnt + 1'b1;
      else                  dly_cnt <= '0;
    end
  end

  // Registered pin/response outputs, computed from the state of the coming cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q         <= 1'b1;
      mosi_q       <= 1'b0;
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      cs_q         <= !cs_active(state_nxt);
      read_valid_q <= (state_nxt == SEND_READ_DATA);
      if (state_nxt == SEND_READ_DATA) read_data_q <= rx_sr;

      if (!is_tx(state_nxt))
        mosi_q <= 1'b0;
      else if (bit_start)
        mosi_q <= (state == IDLE) ? cmd_if.cmd_data[CMD_WIDTH-1] : tx_sr[CMD_WIDTH-2];
    end
  end

  assign cs                = cs_q;
  assign mosi              = mosi_q;
  assign cmd_if.cmd_ready  = (state == IDLE);
  assign cmd_if.read_valid = read_valid_q;
  assign cmd_if.read_data  = read_data_q;

endmodule

// File: tb/tb_spi_master_fsm.sv
// Directed bench for spi_master_fsm: a vector table of whole transactions plus
// hand-written busy, back-to-back and mid-read reset sequences.
module tb_spi_master_fsm;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic sclk, cs, mosi;
  logic miso  = 1'b0;

  spi_master_fsm_if #(.CMD_WIDTH(12), .DATA_WIDTH(8)) cmd_if ();

  spi_master_fsm dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd_if (cmd_if),
    .sclk   (sclk),
    .cs     (cs),
    .mosi   (mosi),
    .miso   (miso)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // SPI slave model: presents read data bit k during the low phase before data-phase rise k.
  logic [7:0] slave_byte = 8'h00;
  int         s_rises    = 0;
  logic       s_prev     = 1'b0;

  always @(negedge clk) begin
    if (cs === 1'b1) s_rises = 0;
    else if (sclk === 1'b1 && s_prev === 1'b0) s_rises = s_rises + 1;
    s_prev = sclk;
    if (sclk === 1'b0)
      miso = (s_rises >= 4 && s_rises < 12) ? slave_byte[11 - s_rises] : 1'b0;
  end

  typedef struct {
    logic [11:0] cmd;
    logic [7:0]  sb;
    logic [11:0] exp_mosi;
    int          exp_cs_low;
    int          exp_max_low;
    int          exp_rv;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [6];

  int          cs_low, pulses, rv_cnt, max_low, mosi_bad;
  logic [11:0] mbits;
  logic [7:0]  rv_data;
  bit          ready_drop, tmo;

  task automatic wait_ready();
    for (int n = 0; n < 50 && cmd_if.cmd_ready !== 1'b1; n++) @(negedge clk);
  endtask

  task automatic run_txn(input logic [11:0] cmd, input logic [7:0] sb, input bit poke,
                         output int o_cs_low, output int o_pulses, output logic [11:0] o_mbits,
                         output int o_rv, output logic [7:0] o_rd, output int o_max_low,
                         output int o_mosi_bad, output bit o_ready_drop, output bit o_tmo);
    int   run, post;
    logic prev;
    o_cs_low = 0; o_pulses = 0; o_mbits = '0; o_rv = 0; o_rd = '0;
    o_max_low = 0; o_mosi_bad = 0; o_tmo = 1'b1; run = 0; post = 0; prev = 1'b0;
    slave_byte = sb;
    wait_ready();
    cmd_if.cmd_data  = cmd;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    o_ready_drop = (cmd_if.cmd_ready === 1'b0);
    for (int n = 0; n < 1000; n++) begin
      if (poke) begin
        cmd_if.cmd_valid = (n >= 30 && n < 35);
        cmd_if.cmd_data  = 12'h3FF;
      end
      if (cs === 1'b0) begin
        o_cs_low++;
        if (sclk === 1'b0) begin
          run++;
          if (run > o_max_low) o_max_low = run;
          if (run > 10 && mosi !== 1'b0) o_mosi_bad++;
        end else run = 0;
      end else begin
        run = 0;
        post++;
      end
      if (sclk === 1'b1 && prev === 1'b0) begin
        o_pulses++;
        o_mbits = {o_mbits[10:0], mosi};
      end
      prev = sclk;
      if (cmd_if.read_valid === 1'b1) begin
        o_rv++;
        o_rd = cmd_if.read_data;
      end
      if (post == 4) begin
        o_tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seg, gap, low2, p2, rvb, post, rv_r;
    logic [11:0] m2;
    logic [7:0]  rdb;
    logic        prev;
    bit          done;

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data  = '0;

    vecs[0] = '{12'hDEA, 8'h00, 12'hDEA, 120, 5,   0, 8'h00};
    vecs[1] = '{12'h500, 8'h5D, 12'h500, 300, 185, 1, 8'h5D};
    vecs[2] = '{12'h800, 8'h00, 12'h800, 120, 5,   0, 8'h5D};
    vecs[3] = '{12'hFFF, 8'h00, 12'hFFF, 120, 5,   0, 8'h5D};
    vecs[4] = '{12'h7AB, 8'hA5, 12'h700, 300, 185, 1, 8'hA5};
    vecs[5] = '{12'h000, 8'h81, 12'h000, 300, 185, 1, 8'h81};

    // Reset
    #1 rst_n = 1'b0;
    #50;
    chk("rst_sclk",       32'(sclk), 32'd0);
    chk("rst_cs",         32'(cs), 32'd1);
    chk("rst_mosi",       32'(mosi), 32'd0);
    chk("rst_cmd_ready",  32'(cmd_if.cmd_ready), 32'd1);
    chk("rst_read_valid", 32'(cmd_if.read_valid), 32'd0);
    chk("rst_read_data",  32'(cmd_if.read_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_cs", 32'(cs), 32'd1);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].cmd, vecs[i].sb, 1'b0, cs_low, pulses, mbits, rv_cnt, rv_data,
              max_low, mosi_bad, ready_drop, tmo);
      chk($sformatf("v%0d_ready_drop", i), 32'(ready_drop), 32'd1);
      chk($sformatf("v%0d_timeout", i),    32'(tmo), 32'd0);
      chk($sformatf("v%0d_cs_low", i),     32'(cs_low), 32'(vecs[i].exp_cs_low));
      chk($sformatf("v%0d_sclk_pulses", i), 32'(pulses), 32'd12);
      chk($sformatf("v%0d_mosi_bits", i),  32'(mbits), 32'(vecs[i].exp_mosi));
      chk($sformatf("v%0d_max_sclk_low", i), 32'(max_low), 32'(vecs[i].exp_max_low));
      chk($sformatf("v%0d_mosi_idle_low", i), 32'(mosi_bad), 32'd0);
      chk($sformatf("v%0d_read_valid_cnt", i), 32'(rv_cnt), 32'(vecs[i].exp_rv));
      if (vecs[i].exp_rv != 0)
        chk($sformatf("v%0d_read_pulse_data", i), 32'(rv_data), 32'(vecs[i].exp_rd));
      chk($sformatf("v%0d_read_data_hold", i), 32'(cmd_if.read_data), 32'(vecs[i].exp_rd));
      chk($sformatf("v%0d_ready_after", i), 32'(cmd_if.cmd_ready), 32'd1);
    end

    // Busy: cmd_valid pulsed mid-write must be ignored
    run_txn(12'hDEA, 8'h00, 1'b1, cs_low, pulses, mbits, rv_cnt, rv_data,
            max_low, mosi_bad, ready_drop, tmo);
    chk("busy_timeout", 32'(tmo), 32'd0);
    chk("busy_cs_low",  32'(cs_low), 32'd120);
    chk("busy_pulses",  32'(pulses), 32'd12);
    chk("busy_mosi",    32'(mbits), 32'hDEA);
    chk("busy_rv",      32'(rv_cnt), 32'd0);
    repeat (3) @(negedge clk);
    chk("busy_no_requeue_cs",    32'(cs), 32'd1);
    chk("busy_no_requeue_ready", 32'(cmd_if.cmd_ready), 32'd1);

    // Back-to-back: write then read presented as soon as ready returns
    slave_byte = 8'h3C;
    seg = 0; gap = 0; low2 = 0; p2 = 0; rvb = 0; post = 0; m2 = '0; rdb = '0;
    prev = 1'b0; done = 1'b0;
    wait_ready();
    cmd_if.cmd_data  = 12'h996;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_data = 12'h600;
    for (int n = 0; n < 2000; n++) begin
      if (cs === 1'b1) begin
        if (seg == 0) seg = 1;
        if (seg == 1) gap++;
        else if (seg >= 2) begin
          seg = 3;
          post++;
        end
      end else begin
        if (seg == 1) begin
          seg = 2;
          cmd_if.cmd_valid = 1'b0;
        end
        if (seg == 2) low2++;
      end
      if (seg == 2 && sclk === 1'b1 && prev === 1'b0) begin
        p2++;
        m2 = {m2[10:0], mosi};
      end
      prev = sclk;
      if (cmd_if.read_valid === 1'b1) begin
        rvb++;
        rdb = cmd_if.read_data;
      end
      if (post == 4) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;
    chk("b2b_timeout",   32'(done), 32'd1);
    chk("b2b_cs_gap",    32'(gap), 32'd1);
    chk("b2b_rd_cs_low", 32'(low2), 32'd300);
    chk("b2b_rd_pulses", 32'(p2), 32'd12);
    chk("b2b_rd_mosi",   32'(m2), 32'h600);
    chk("b2b_rv_cnt",    32'(rvb), 32'd1);
    chk("b2b_rv_data",   32'(rdb), 32'h3C);

    // Reset during the read turnaround
    slave_byte = 8'hC3;
    rv_r = 0;
    wait_ready();
    cmd_if.cmd_data  = 12'h355;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (cmd_if.read_valid === 1'b1) rv_r++;
    end
    chk("mid_delay_cs",   32'(cs), 32'd0);
    chk("mid_delay_sclk", 32'(sclk), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs",        32'(cs), 32'd1);
    chk("mid_rst_sclk",      32'(sclk), 32'd0);
    chk("mid_rst_mosi",      32'(mosi), 32'd0);
    chk("mid_rst_read_data", 32'(cmd_if.read_data), 32'h00);
    chk("mid_rst_ready",     32'(cmd_if.cmd_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      if (cmd_if.read_valid === 1'b1) rv_r++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (cmd_if.read_valid === 1'b1) rv_r++;
    end
    chk("mid_rst_no_read_valid", 32'(rv_r), 32'd0);

    run_txn(12'hA5C, 8'h00, 1'b0, cs_low, pulses, mbits, rv_cnt, rv_data,
            max_low, mosi_bad, ready_drop, tmo);
    chk("after_rst_timeout", 32'(tmo), 32'd0);
    chk("after_rst_cs_low",  32'(cs_low), 32'd120);
    chk("after_rst_pulses",  32'(pulses), 32'd12);
    chk("after_rst_mosi",    32'(mbits), 32'hA5C);
    chk("after_rst_rv",      32'(rv_cnt), 32'd0);
    chk("after_rst_rd",      32'(cmd_if.read_data), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
